// File: rtl/ddr2_calib_seq_monitor.sv
`default_nettype none
// ============================================================================
// ddr2_calib_seq_monitor : per-rank DDR2 OCD/ZQ calibration sequence checker
// Revision 1.0
// ============================================================================
module ddr2_calib_seq_monitor #(
    parameter int                    NUM_RANKS           = 2,
    parameter int                    ADDR_WIDTH          = 13,
    parameter int                    BA_WIDTH            = 2,
    parameter int                    EMRS1_BA_VAL        = 1,
    parameter logic [ADDR_WIDTH-1:0] EMRS1_OCD_ENTER_VAL = 13'h380,
    parameter logic [ADDR_WIDTH-1:0] EMRS1_OCD_EXIT_VAL  = 13'h000,
    parameter logic [ADDR_WIDTH-1:0] ZQCAL_CMD_A_VAL     = 13'h400,
    parameter int                    ZQCAL_CMD_BA_VAL    = 0,
    parameter int                    TMRD_CYCLES         = 2,
    parameter int                    TOCD_MIN_CYCLES     = 0,
    parameter int                    TOCD_MAX_CYCLES     = 0,
    parameter int                    TZQINIT_CYCLES      = 0,
    parameter int                    CNT_WIDTH           = 16,
    parameter int                    ERR_CNT_WIDTH       = 8,
    parameter int                    FATAL_ON_ERR        = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     monitor_en,
    input  logic                     clear_err,
    input  logic                     cke_pad,
    input  logic [NUM_RANKS-1:0]     csbar_pad,
    input  logic                     rasbar_pad,
    input  logic                     casbar_pad,
    input  logic                     webar_pad,
    input  logic [BA_WIDTH-1:0]      ba_pad,
    input  logic [ADDR_WIDTH-1:0]    a_pad,
    output logic [NUM_RANKS-1:0]     rank_calibrated,
    output logic                     all_calibrated,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [2:0]               err_rank,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_OCD_ACTIVE = 3'd1,
        S_OCD_DONE   = 3'd2,
        S_ZQ_WAIT    = 3'd3,
        S_CALIBRATED = 3'd4
    } state_t;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t C_TMRD     = cnt_t'(TMRD_CYCLES);
    localparam cnt_t C_TOCD_MIN = cnt_t'(TOCD_MIN_CYCLES);
    localparam cnt_t C_TOCD_MAX = cnt_t'(TOCD_MAX_CYCLES);
    localparam cnt_t C_TZQINIT  = cnt_t'(TZQINIT_CYCLES);

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic                 dec_en, lm_cmd, zq_cmd, nop_cmd, enter_pat, exit_pat;
    logic [NUM_RANKS-1:0] lm_v, enter_v, exit_v, zq_v, busy_v;

    assign dec_en    = cke_pad & monitor_en;
    assign lm_cmd    = ~rasbar_pad & ~casbar_pad & ~webar_pad;
    assign nop_cmd   = rasbar_pad & casbar_pad & webar_pad;
    assign enter_pat = (ba_pad == BA_WIDTH'(EMRS1_BA_VAL)) && (a_pad == EMRS1_OCD_ENTER_VAL);
    assign exit_pat  = (ba_pad == BA_WIDTH'(EMRS1_BA_VAL)) && (a_pad == EMRS1_OCD_EXIT_VAL);
    assign zq_cmd    = rasbar_pad & casbar_pad & ~webar_pad
                     & (ba_pad == BA_WIDTH'(ZQCAL_CMD_BA_VAL)) & (a_pad == ZQCAL_CMD_A_VAL);

    // A CA word may select several ranks; each rank decodes it independently.
    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        logic act;
        assign act        = dec_en & ~csbar_pad[r];
        assign lm_v[r]    = act & lm_cmd;
        assign enter_v[r] = act & lm_cmd & enter_pat;
        assign exit_v[r]  = act & lm_cmd & exit_pat;
        assign zq_v[r]    = act & zq_cmd;
        assign busy_v[r]  = act & ~nop_cmd;
    end

    state_t               state_q [NUM_RANKS];
    state_t               state_d [NUM_RANKS];
    cnt_t                 lm_gap_q [NUM_RANKS];
    cnt_t                 lm_gap_d [NUM_RANKS];
    cnt_t                 ocd_cnt_q [NUM_RANKS];
    cnt_t                 ocd_cnt_d [NUM_RANKS];
    cnt_t                 zq_cnt_q [NUM_RANKS];
    cnt_t                 zq_cnt_d [NUM_RANKS];
    logic [7:1]           viol [NUM_RANKS];
    logic [NUM_RANKS-1:0] lm_seen_q, lm_seen_d, tmo_q, tmo_d, rank_cal_q, rank_cal_d;
    logic                 all_cal_q, all_cal_d, found;
    logic                 err_valid_q, err_valid_d, err_sticky_q, err_sticky_d;
    logic [2:0]           err_code_q, err_code_d, err_rank_q, err_rank_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d, cnt_base;

    always_comb begin
        found      = 1'b0;
        err_code_d = '0;
        err_rank_d = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            state_d[r]   = state_q[r];
            lm_gap_d[r]  = lm_gap_q[r];
            ocd_cnt_d[r] = ocd_cnt_q[r];
            zq_cnt_d[r]  = zq_cnt_q[r];
            lm_seen_d[r] = lm_seen_q[r];
            tmo_d[r]     = tmo_q[r];
            viol[r]      = '0;
            if (monitor_en) begin
                lm_gap_d[r]  = lm_v[r] ? '0 : sat_inc(lm_gap_q[r]);
                lm_seen_d[r] = lm_seen_q[r] | lm_v[r];
                if ((TMRD_CYCLES != 0) && lm_v[r] && lm_seen_q[r] && (lm_gap_q[r] < C_TMRD))
                    viol[r][5] = 1'b1;
                case (state_q[r])
                    S_IDLE: begin
                        if (enter_v[r]) begin
                            state_d[r]   = S_OCD_ACTIVE;
                            ocd_cnt_d[r] = '0;
                            tmo_d[r]     = 1'b0;
                        end
                        viol[r][2] = exit_v[r];
                        viol[r][4] = zq_v[r];
                    end
                    S_OCD_ACTIVE: begin
                        ocd_cnt_d[r] = sat_inc(ocd_cnt_q[r]);
                        viol[r][1]   = enter_v[r];
                        viol[r][4]   = zq_v[r];
                        // tmo_q keeps a saturated counter from re-flagging the timeout
                        if ((TOCD_MAX_CYCLES != 0) && !tmo_q[r] && (ocd_cnt_q[r] == C_TOCD_MAX)) begin
                            viol[r][7] = 1'b1;
                            tmo_d[r]   = 1'b1;
                        end
                        if (exit_v[r]) begin
                            state_d[r] = S_OCD_DONE;
                            if ((TOCD_MIN_CYCLES != 0) && (ocd_cnt_q[r] < C_TOCD_MIN))
                                viol[r][3] = 1'b1;
                        end
                    end
                    S_OCD_DONE: begin
                        if (zq_v[r]) begin
                            zq_cnt_d[r] = '0;
                            state_d[r]  = (TZQINIT_CYCLES == 0) ? S_CALIBRATED : S_ZQ_WAIT;
                        end
                    end
                    S_ZQ_WAIT: begin
                        if (busy_v[r]) begin
                            viol[r][6]  = 1'b1;
                            zq_cnt_d[r] = '0;
                        end else if (zq_cnt_q[r] >= C_TZQINIT) begin
                            state_d[r] = S_CALIBRATED;
                        end else begin
                            zq_cnt_d[r] = sat_inc(zq_cnt_q[r]);
                        end
                    end
                    S_CALIBRATED: begin
                        if (enter_v[r]) begin
                            state_d[r]   = S_OCD_ACTIVE;
                            ocd_cnt_d[r] = '0;
                            tmo_d[r]     = 1'b0;
                        end
                    end
                    default: state_d[r] = S_IDLE;
                endcase
            end
            rank_cal_d[r] = (state_d[r] == S_CALIBRATED);
            // Lowest rank wins; within it the downward scan leaves the lowest code.
            if (!found && (viol[r] != '0)) begin
                found      = 1'b1;
                err_rank_d = 3'(r);
                for (int c = 7; c >= 1; c--)
                    if (viol[r][c]) err_code_d = 3'(c);
            end
        end
        all_cal_d    = &rank_cal_d;
        err_valid_d  = found;
        err_sticky_d = (clear_err ? 1'b0 : err_sticky_q) | found;
        cnt_base     = clear_err ? '0 : err_count_q;
        err_count_d  = (found && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= '{default: S_IDLE};
            lm_gap_q     <= '{default: '0};
            ocd_cnt_q    <= '{default: '0};
            zq_cnt_q     <= '{default: '0};
            lm_seen_q    <= '0;
            tmo_q        <= '0;
            rank_cal_q   <= '0;
            all_cal_q    <= 1'b0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            err_rank_q   <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            lm_gap_q     <= lm_gap_d;
            ocd_cnt_q    <= ocd_cnt_d;
            zq_cnt_q     <= zq_cnt_d;
            lm_seen_q    <= lm_seen_d;
            tmo_q        <= tmo_d;
            rank_cal_q   <= rank_cal_d;
            all_cal_q    <= all_cal_d;
            err_valid_q  <= err_valid_d;
            err_code_q   <= err_code_d;
            err_rank_q   <= err_rank_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

`ifndef SYNTHESIS
    if (FATAL_ON_ERR != 0) begin : g_fatal
        always_ff @(posedge clk)
            if (err_valid_q) $fatal(1, "calibration violation code %0d rank %0d", err_code_q, err_rank_q);
    end
`endif

    assign rank_calibrated = rank_cal_q;
    assign all_calibrated  = all_cal_q;
    assign err_valid       = err_valid_q;
    assign err_code        = err_code_q;
    assign err_rank        = err_rank_q;
    assign err_sticky      = err_sticky_q;
    assign err_count       = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr2_calib_seq_monitor.sv
`default_nettype none
// ============================================================================
// tb_ddr2_calib_seq_monitor : directed bench for the DDR2 calibration monitor
// Revision 1.0
// ============================================================================
module tb_ddr2_calib_seq_monitor;

    logic        clk = 1'b0;
    logic        reset_n, monitor_en, clear_err, cke_pad;
    logic [1:0]  csbar_pad;
    logic        rasbar_pad, casbar_pad, webar_pad;
    logic [1:0]  ba_pad;
    logic [12:0] a_pad;
    logic [1:0]  rank_calibrated;
    logic        all_calibrated, err_valid, err_sticky;
    logic [2:0]  err_code, err_rank;
    logic [7:0]  err_count;
    int          checks = 0;
    int          errors = 0;

    ddr2_calib_seq_monitor #(
        .NUM_RANKS(2), .TMRD_CYCLES(2), .TOCD_MIN_CYCLES(20),
        .TOCD_MAX_CYCLES(50), .TZQINIT_CYCLES(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .monitor_en(monitor_en), .clear_err(clear_err),
        .cke_pad(cke_pad), .csbar_pad(csbar_pad), .rasbar_pad(rasbar_pad),
        .casbar_pad(casbar_pad), .webar_pad(webar_pad), .ba_pad(ba_pad), .a_pad(a_pad),
        .rank_calibrated(rank_calibrated), .all_calibrated(all_calibrated),
        .err_valid(err_valid), .err_code(err_code), .err_rank(err_rank),
        .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_nop();
        csbar_pad = 2'b11; rasbar_pad = 1'b1; casbar_pad = 1'b1; webar_pad = 1'b1;
        ba_pad = 2'd0; a_pad = 13'd0;
    endtask

    // One CA word for one clock; mask bit set = rank selected.
    task automatic cmd(input logic [1:0] mask, input logic ras, input logic cas,
                       input logic we, input logic [1:0] ba, input logic [12:0] a);
        csbar_pad = ~mask; rasbar_pad = ras; casbar_pad = cas; webar_pad = we;
        ba_pad = ba; a_pad = a;
        tick(1);
        set_nop();
    endtask

    task automatic ocd_enter(input logic [1:0] m); cmd(m, 1'b0, 1'b0, 1'b0, 2'd1, 13'h380); endtask
    task automatic ocd_exit(input logic [1:0] m);  cmd(m, 1'b0, 1'b0, 1'b0, 2'd1, 13'h000); endtask
    task automatic emrs(input logic [1:0] m);      cmd(m, 1'b0, 1'b0, 1'b0, 2'd1, 13'h004); endtask
    task automatic mrs(input logic [1:0] m);       cmd(m, 1'b0, 1'b0, 1'b0, 2'd0, 13'h000); endtask
    task automatic zqcal(input logic [1:0] m);     cmd(m, 1'b1, 1'b1, 1'b0, 2'd0, 13'h400); endtask
    task automatic activate(input logic [1:0] m);  cmd(m, 1'b0, 1'b1, 1'b1, 2'd0, 13'h000); endtask

    task automatic do_reset();
        reset_n = 1'b0; monitor_en = 1'b1; clear_err = 1'b0; cke_pad = 1'b1;
        set_nop();
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rank_calibrated, all_calibrated, err_valid, err_code, err_rank, err_sticky, err_count} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h, expected 0",
                     {rank_calibrated, all_calibrated, err_valid, err_code, err_rank, err_sticky, err_count});
        end
    endtask

    task automatic test_calibration_flow();
        do_reset();
        ocd_enter(2'b11);
        tick(24);
        ocd_exit(2'b11);
        zqcal(2'b11);
        tick(8);
        checks++;
        if (rank_calibrated !== 2'b00) begin
            errors++; $display("FAIL cal_early: got %b, expected 00", rank_calibrated);
        end
        tick(1);
        checks++;
        if (rank_calibrated !== 2'b11) begin
            errors++; $display("FAIL cal_done: got %b, expected 11", rank_calibrated);
        end
        checks++;
        if (all_calibrated !== 1'b1) begin
            errors++; $display("FAIL all_cal: got %b, expected 1", all_calibrated);
        end
        checks++;
        if ({err_sticky, err_count} !== 9'd0) begin
            errors++; $display("FAIL cal_no_err: got sticky %b count %0d, expected 0 0", err_sticky, err_count);
        end
    endtask

    task automatic test_tocd_min();
        do_reset();
        ocd_enter(2'b01);
        tick(4);
        ocd_exit(2'b01);
        checks++;
        if ({err_valid, err_code, err_rank, err_count} !== {1'b1, 3'd3, 3'd0, 8'd1}) begin
            errors++;
            $display("FAIL tocd_min: got v%b c%0d r%0d n%0d, expected v1 c3 r0 n1", err_valid, err_code, err_rank, err_count);
        end
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++; $display("FAIL tocd_min_sticky: got %b, expected 1", err_sticky);
        end
        tick(1);
        checks++;
        if (err_valid !== 1'b0) begin
            errors++; $display("FAIL tocd_min_pulse: got %b, expected 0", err_valid);
        end
        zqcal(2'b01);
        tick(9);
        checks++;
        if ({rank_calibrated, err_count} !== {2'b01, 8'd1}) begin
            errors++; $display("FAIL tocd_min_done: got cal %b count %0d, expected 01 1", rank_calibrated, err_count);
        end
    endtask

    task automatic test_multi_rank();
        do_reset();
        mrs(2'b10);
        ocd_exit(2'b11);
        checks++;
        if ({err_valid, err_code, err_rank, err_count} !== {1'b1, 3'd2, 3'd0, 8'd1}) begin
            errors++;
            $display("FAIL rank_prio: got v%b c%0d r%0d n%0d, expected v1 c2 r0 n1", err_valid, err_code, err_rank, err_count);
        end
        do_reset();
        mrs(2'b01);
        ocd_exit(2'b01);
        checks++;
        if ({err_valid, err_code, err_rank} !== {1'b1, 3'd2, 3'd0}) begin
            errors++; $display("FAIL code_prio: got v%b c%0d r%0d, expected v1 c2 r0", err_valid, err_code, err_rank);
        end
        do_reset();
        zqcal(2'b10);
        checks++;
        if ({err_valid, err_code, err_rank} !== {1'b1, 3'd4, 3'd1}) begin
            errors++; $display("FAIL zq_idle_r1: got v%b c%0d r%0d, expected v1 c4 r1", err_valid, err_code, err_rank);
        end
    endtask

    task automatic test_tmrd();
        do_reset();
        emrs(2'b01);
        emrs(2'b01);
        checks++;
        if ({err_valid, err_code, err_rank} !== {1'b1, 3'd5, 3'd0}) begin
            errors++; $display("FAIL tmrd: got v%b c%0d r%0d, expected v1 c5 r0", err_valid, err_code, err_rank);
        end
        do_reset();
        emrs(2'b01);
        cke_pad = 1'b0;
        emrs(2'b01);
        cke_pad = 1'b1;
        checks++;
        if (err_valid !== 1'b0) begin
            errors++; $display("FAIL tmrd_cke_low: got %b, expected 0", err_valid);
        end
        tick(3);
        emrs(2'b01);
        checks++;
        if ({err_valid, err_count} !== 9'd0) begin
            errors++; $display("FAIL tmrd_spaced: got v%b n%0d, expected v0 n0", err_valid, err_count);
        end
        monitor_en = 1'b0;
        emrs(2'b01);
        emrs(2'b01);
        checks++;
        if ({err_valid, err_count} !== 9'd0) begin
            errors++; $display("FAIL monitor_off: got v%b n%0d, expected v0 n0", err_valid, err_count);
        end
        monitor_en = 1'b1;
    endtask

    task automatic test_timeout_clear();
        do_reset();
        ocd_enter(2'b01);
        tick(50);
        checks++;
        if (err_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_early: got %b, expected 0", err_valid);
        end
        tick(1);
        checks++;
        if ({err_valid, err_code, err_rank} !== {1'b1, 3'd7, 3'd0}) begin
            errors++; $display("FAIL timeout: got v%b c%0d r%0d, expected v1 c7 r0", err_valid, err_code, err_rank);
        end
        tick(11);
        checks++;
        if (err_count !== 8'd1) begin
            errors++; $display("FAIL timeout_once: got %0d, expected 1", err_count);
        end
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        checks++;
        if ({err_sticky, err_count} !== 9'd0) begin
            errors++; $display("FAIL clear: got sticky %b count %0d, expected 0 0", err_sticky, err_count);
        end
        tick(2);
        emrs(2'b01);
        emrs(2'b01);
        emrs(2'b01);
        checks++;
        if (err_count !== 8'd2) begin
            errors++; $display("FAIL count_inc: got %0d, expected 2", err_count);
        end
        tick(3);
        emrs(2'b01);
        clear_err = 1'b1;
        emrs(2'b01);
        clear_err = 1'b0;
        checks++;
        if ({err_valid, err_sticky, err_count} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL clear_with_err: got v%b s%b n%0d, expected v1 s1 n1", err_valid, err_sticky, err_count);
        end
    endtask

    task automatic test_zqinit_busy_reset();
        do_reset();
        ocd_enter(2'b01);
        tick(24);
        ocd_exit(2'b01);
        zqcal(2'b01);
        tick(3);
        activate(2'b01);
        checks++;
        if ({err_valid, err_code, err_rank} !== {1'b1, 3'd6, 3'd0}) begin
            errors++; $display("FAIL zqinit_busy: got v%b c%0d r%0d, expected v1 c6 r0", err_valid, err_code, err_rank);
        end
        tick(8);
        checks++;
        if (rank_calibrated !== 2'b00) begin
            errors++; $display("FAIL zq_restart_early: got %b, expected 00", rank_calibrated);
        end
        tick(1);
        checks++;
        if (rank_calibrated !== 2'b01) begin
            errors++; $display("FAIL zq_restart_done: got %b, expected 01", rank_calibrated);
        end
        ocd_enter(2'b01);
        checks++;
        if ({rank_calibrated, err_valid} !== 3'b000) begin
            errors++; $display("FAIL recal_enter: got cal %b v%b, expected 00 0", rank_calibrated, err_valid);
        end
        tick(24);
        ocd_exit(2'b01);
        zqcal(2'b01);
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rank_calibrated, all_calibrated, err_valid, err_code, err_rank, err_sticky, err_count} !== 18'd0) begin
            errors++;
            $display("FAIL async_reset: got %0h, expected 0",
                     {rank_calibrated, all_calibrated, err_valid, err_code, err_rank, err_sticky, err_count});
        end
        tick(1);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; monitor_en = 1'b1; clear_err = 1'b0; cke_pad = 1'b1;
        set_nop();
        test_reset();
        test_calibration_flow();
        test_tocd_min();
        test_multi_rank();
        test_tmrd();
        test_timeout_clear();
        test_zqinit_busy_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
